// File: rtl/alu_result_serializer.sv
// alu_result_serializer
//
// Purpose: captures one RESULT_W-bit ALU result and the operation code that
// produced it, then streams the result out least-significant word first over
// a valid/ready interface. Only the words that can be non-zero for that
// operation are sent: a sum needs RESULT_W/2+1 bits, a product needs all of
// RESULT_W, and any other operation yields a single zero word. The final word
// is flagged with out_last.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   load_valid result/operation valid for capture
//   load_ready serializer can accept a capture (IDLE only)
//   result     ALU result bus, RESULT_W bits
//   operation  2'b00 add, 2'b01 multiply, others give a zero result
//   out_valid  out_data holds a valid word
//   out_ready  consumer accepts the word this cycle
//   out_data   current result word, WORD_W bits
//   out_index  index of the current word, 0 = least significant
//   out_last   current word is the final word of this result
//   busy       high while streaming
module alu_result_serializer #(
  parameter int WORD_W   = 32,
  parameter int RESULT_W = 1024,
  localparam int NUM_WORDS = RESULT_W / WORD_W,
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [RESULT_W-1:0] result,
  input  logic [1:0]          operation,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic [IDX_W-1:0]    out_index,
  output logic                out_last,
  output logic                busy
);

  // A sum of two RESULT_W/2-bit operands carries at most one extra bit.
  localparam int ADD_WORDS = (RESULT_W / 2 + 1 + WORD_W - 1) / WORD_W;
  localparam logic [IDX_W-1:0] ADD_LAST = IDX_W'(ADD_WORDS - 1);
  localparam logic [IDX_W-1:0] MUL_LAST = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [RESULT_W-1:0] shreg;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    last_idx;
  logic                capture;
  logic                advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Word outputs are gated by state so that IDLE (and reset) present zeros,
  // independent of whatever the last stream left in the shift register.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    out_data   = '0;
    out_index  = '0;
    out_last   = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          capture   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = shreg[WORD_W-1:0];
        out_index = idx;
        out_last  = (idx == last_idx);
        if (out_ready) begin
          if (idx == last_idx) begin
            state_nxt = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The word count is latched at capture; operation is never looked at again.
  // Non-add/multiply codes discard the bus so stray bits can never leak out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      idx      <= '0;
      last_idx <= '0;
    end else if (capture) begin
      shreg <= operation[1] ? '0 : result;
      idx   <= '0;
      case (operation)
        2'b00:   last_idx <= ADD_LAST;
        2'b01:   last_idx <= MUL_LAST;
        default: last_idx <= '0;
      endcase
    end else if (advance) begin
      shreg <= shreg >> WORD_W;
      idx   <= idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed testbench for alu_result_serializer (WORD_W=32, RESULT_W=1024).
module tb_alu_result_serializer;

  logic          clk;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [1023:0] result;
  logic [1:0]    operation;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [4:0]    out_index;
  logic          out_last;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Stream kinds used by exp_word
  localparam int K_ADD2  = 0;  // 1 + 1
  localparam int K_MUL   = 1;  // all-ones * all-ones (512 bit)
  localparam int K_ZERO  = 2;  // op 10
  localparam int K_ADDF  = 3;  // fresh add after reset
  localparam int K_ADD55 = 4;  // re-presented load after ignore test

  alu_result_serializer #(.WORD_W(32), .RESULT_W(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .result     (result),
    .operation  (operation),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Hand-derived expected words.
  // Product 2^1024 - 2^513 + 1: bit 0 set, bits 513..1023 set.
  function automatic logic [31:0] exp_word(input int kind, input int i);
    case (kind)
      K_ADD2:  return (i == 0) ? 32'h0000_0002 : 32'h0;
      K_MUL: begin
        if (i == 0)       return 32'h0000_0001;
        else if (i < 16)  return 32'h0;
        else if (i == 16) return 32'hFFFF_FFFE;
        else              return 32'hFFFF_FFFF;
      end
      K_ADDF: begin
        if (i == 0)       return 32'hDEAD_BEEF;
        else if (i == 16) return 32'h0000_0001;
        else              return 32'h0;
      end
      K_ADD55: return (i == 0) ? 32'h0000_0055 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [1023:0] res, input logic [1:0] op);
    load_valid = 1'b1;
    result     = res;
    operation  = op;
    check("cap_load_ready", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
    result     = '0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"},  32'(out_valid),  32'd0);
    check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_out_data"},   out_data,        32'd0);
    check({tag, "_out_index"},  32'(out_index),  32'd0);
    check({tag, "_out_last"},   32'(out_last),   32'd0);
  endtask

  // Consumes a whole stream starting right after the capture edge.
  task automatic run_stream(input int kind, input int nwords, input int stall_at,
                            input int stall_len, input int pulse_at);
    int hs;
    hs = 0;
    out_ready = 1'b1;
    for (int i = 0; i < nwords; i++) begin
      check("valid", 32'(out_valid), 32'd1);
      check("busy",  32'(busy),      32'd1);
      check("index", 32'(out_index), 32'(i));
      check("data",  out_data,       exp_word(kind, i));
      check("last",  32'(out_last),  32'(i == nwords - 1));
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_index", 32'(out_index), 32'(i));
          check("stall_data",  out_data,       exp_word(kind, i));
          check("stall_last",  32'(out_last),  32'(i == nwords - 1));
        end
        out_ready = 1'b1;
      end
      if (i == pulse_at) begin
        load_valid = 1'b1;
        result     = {32{32'hA5A5_A5A5}};
        operation  = 2'b00;
        check("pulse_load_ready", 32'(load_ready), 32'd0);
      end
      if (out_valid && out_ready) hs++;
      tick();
      load_valid = 1'b0;
    end
    check("handshakes", 32'(hs), 32'(nwords));
    check_idle("end");
  endtask

  logic [1023:0] mul_res;
  logic [1023:0] addf_res;

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    result     = '0;
    operation  = 2'b00;
    out_ready  = 1'b0;
    mul_res    = ({1024{1'b1}} << 513) | 1024'd1;
    addf_res   = '0;
    addf_res[31:0]     = 32'hDEAD_BEEF;
    addf_res[512]      = 1'b1;
    addf_res[671:640]  = 32'hFFFF_FFFF;  // malformed bits beyond the sum width

    #2;
    check_idle("rst");
    #20 rst = 1'b0;
    check("rel_load_ready", 32'(load_ready), 32'd1);
    tick();

    // Add 1+1: 17 words
    capture(1024'd2, 2'b00);
    run_stream(K_ADD2, 17, -1, 0, -1);

    // Multiply all-ones squared: 32 words
    capture(mul_res, 2'b01);
    run_stream(K_MUL, 32, -1, 0, -1);

    // Backpressure at index 3 for 5 cycles
    capture(mul_res, 2'b01);
    run_stream(K_MUL, 32, 3, 5, -1);

    // load_valid pulse at index 10 must be ignored
    capture(mul_res, 2'b01);
    run_stream(K_MUL, 32, -1, 0, 10);
    tick();
    check("no_late_capture", 32'(out_valid), 32'd0);
    capture(1024'h55, 2'b00);
    run_stream(K_ADD55, 17, -1, 0, -1);

    // Op 10 with all-ones result: one zero word
    capture({1024{1'b1}}, 2'b10);
    run_stream(K_ZERO, 1, -1, 0, -1);

    // Reset mid-stream at index 7
    capture(mul_res, 2'b01);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("pre_rst_index", 32'(out_index), 32'd7);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_idle("midrst");
    #2 rst = 1'b0;
    tick();
    check_idle("post_rst");
    capture(addf_res, 2'b00);
    run_stream(K_ADDF, 17, -1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_serializer.md
# alu_result_serializer

Downstream stage of the 512-bit ALU. Captures one 1024-bit `result` together with the `operation` code that produced it. Streams the result out as WORD_W-bit words, least-significant word first, over a valid/ready interface. Only the words that can be non-zero for that operation are sent, and the final word is flagged.

## Interface

- WORD_W, default 32: output word width; must divide RESULT_W.
- RESULT_W, default 1024: captured result width (2 × 512-bit operand width).
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  `result`/`operation` are valid for capture.
- load_ready  out  1  serializer can accept a capture (IDLE only).
- result  in  RESULT_W  ALU result bus.
- operation  in  2  ALU operation code: 00 add, 01 multiply, other = zero result.
- out_valid  out  1  `out_data` holds a valid word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  WORD_W  current result word.
- out_index  out  clog2(RESULT_W/WORD_W)  index of the current word, 0 = least significant.
- out_last  out  1  current word is the final word of this result.
- busy  out  1  high in SEND.

## Operation

- Word counts, fixed at capture from `operation`:
  - 00 (add): ADD_WORDS = ceil((RESULT_W/2 + 1)/WORD_W) = 17. The sum is at most 513 bits.
  - 01 (multiply): RESULT_W/WORD_W = 32.
  - 10/11: 1 word.
- The word count is held in a register; `operation` is not re-sampled after capture.
- FSM has two states, IDLE and SEND.
- IDLE:
  - load_ready=1, out_valid=0, busy=0.
  - On load_valid & load_ready at a clock edge:
    - shift register ← `result`. For op 10/11 it is forced to 0 regardless of `result`.
    - index ← 0.
    - last_idx ← word count − 1.
    - Go to SEND.
- SEND:
  - load_ready=0, out_valid=1, busy=1.
  - out_data = shift register [WORD_W-1:0].
  - out_index = index.
  - out_last = (index == last_idx).
  - On out_valid & out_ready:
    - if out_last: return to IDLE.
    - else: shift register >>= WORD_W, index += 1.
- load_valid during SEND is ignored. No capture and no queueing; the upstream must hold or re-present the load.
- Upper words beyond the word count are never emitted, even if non-zero (e.g. a malformed add result with bits above 512 set).
- Reset (async, any state) → IDLE, shift register=0, index=0, last_idx=0. Outputs take their reset values immediately, without waiting for a clock edge.

## Timing

- Reset values:
  - load_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0.
  - load_ready=1 is valid as soon as rst deasserts.
- Capture at edge N → out_valid=1 with word 0 from cycle N+1. Capture-to-first-word latency is 1 cycle.
- One word per cycle while out_ready stays high. A full multiply result takes 32 cycles in SEND.
- Final handshake at edge M → IDLE at M+1, so load_ready=1 in cycle M+1. A new capture is possible at edge M+1, giving a one-cycle bubble between results.
- Backpressure: while out_valid & !out_ready, out_data, out_index and out_last are held stable, with no advance.
- out_valid never drops in SEND except through reset.
- out_ready is ignored in IDLE.
- Reset asserted mid-stream: out_valid falls asynchronously and the partial result is discarded. After release, nothing resumes.

## Test plan

- Add: result=2 (1+1), op=00, out_ready=1.
  - Required: 17 words, word0=0x00000002, words1–16=0.
  - out_last only at index 16.
  - load_ready returns high the cycle after.
- Multiply: 512-bit all-ones × all-ones (result = 2^1024 − 2^513 + 1), op=01.
  - Required: word0=0x00000001, words1–15=0, word16=0xFFFFFFFE, words17–31=0xFFFFFFFF.
  - out_last at index 31.
- Backpressure: multiply stream, out_ready low for 5 cycles at index 3.
  - Required: out_data/out_index/out_last held constant across those cycles.
  - No word skipped or duplicated; 32 handshakes total.
- Busy/ignore: pulse load_valid with a different result at index 10 of a stream.
  - Required: load_ready=0, current stream unchanged.
  - New value captured only when presented again after returning to IDLE.
- Op 10 with result=all-ones.
  - Required: exactly one word, 0x00000000, with out_last=1.
- Reset mid-stream at index 7.
  - Required: out_valid=0 immediately, all outputs at reset values.
  - A fresh add capture after release streams correctly from index 0.
